// File: rtl/meas_pkg.sv
// Shared types and defaults for the clock measurement blocks.
// Holds the measurement FSM encoding and the counter ceiling helper.
package meas_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 32;

    // Largest counter value that still leaves room for cnt+1.
    function automatic longint unsigned max_count(input int w);
        return (64'd1 << w) - 64'd2;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer plus history flop producing primed rise/fall strobes.
// Edges are masked until the sync chain has flushed after reset.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic inclk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    localparam int PW = $clog2(STAGES + 2);
    localparam logic [PW-1:0] PRIME = PW'(STAGES + 1);

    logic [STAGES-1:0] sync;
    logic              s_d;
    logic [PW-1:0]     pcnt;
    logic              s;
    logic              primed;

    assign s      = sync[STAGES-1];
    assign primed = (pcnt == PRIME);

    always_ff @(posedge inclk) begin
        if (reset) begin
            sync <= '0;
            s_d  <= 1'b0;
            pcnt <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], sig_in};
            s_d  <= s;
            if (!primed)
                pcnt <= pcnt + 1'b1;
        end
    end

    assign rise = primed & s & ~s_d;
    assign fall = primed & ~s & s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in inclk cycles.
// First rise arms the counter; each later rise publishes a result.
module period_meter
    import meas_pkg::*;
#(
    parameter int              CNT_W       = CNT_W_DEF,
    parameter int              SYNC_STAGES = 2,
    parameter longint unsigned MAX_COUNT   = max_count(CNT_W)
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hi_pend;
    logic [CNT_W-1:0] hi_nxt;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] ht_nxt;
    logic             val_nxt;
    logic             to_nxt;
    logic             rise;
    logic             fall;
    logic             meas;
    logic             at_max;

    edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .inclk (inclk),
        .reset (reset),
        .sig_in(sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign meas   = (state == MEASURE);
    assign at_max = (cnt == MAX_C);

    always_ff @(posedge inclk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = MEASURE;
            MEASURE: if (!rise && at_max) state_nxt = IDLE;
        endcase
    end

    // A rise always wins over the ceiling, so a period of MAX_COUNT+1 is published.
    always_comb begin
        cnt_nxt = cnt;
        hi_nxt  = hi_pend;
        per_nxt = period;
        ht_nxt  = high_time;
        val_nxt = 1'b0;
        to_nxt  = timeout;
        unique case (1'b1)
            !meas: begin
                cnt_nxt = '0;
                if (rise)
                    hi_nxt = '0;
            end
            meas && rise: begin
                per_nxt = cnt + 1'b1;
                ht_nxt  = hi_pend;
                val_nxt = 1'b1;
                to_nxt  = 1'b0;
                cnt_nxt = '0;
                hi_nxt  = '0;
            end
            meas && !rise && at_max: begin
                to_nxt  = 1'b1;
                cnt_nxt = '0;
            end
            default: begin
                cnt_nxt = cnt + 1'b1;
                if (fall)
                    hi_nxt = cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            cnt       <= '0;
            hi_pend   <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            hi_pend   <= hi_nxt;
            period    <= per_nxt;
            high_time <= ht_nxt;
            valid     <= val_nxt;
            timeout   <= to_nxt;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a default-width instance and a
// narrow instance with a small ceiling share clock, reset and input.
module tb_period_meter;

    logic        inclk  = 1'b0;
    logic        reset  = 1'b1;
    logic        sig_in = 1'b0;

    logic [31:0] period_b;
    logic [31:0] high_b;
    logic        valid_b;
    logic        timeout_b;
    logic [7:0]  period_s;
    logic [7:0]  high_s;
    logic        valid_s;
    logic        timeout_s;

    int          errors = 0;
    int          checks = 0;
    int          nb;
    int          ns;
    logic [31:0] pb;
    logic [31:0] hb;
    logic [31:0] ps;
    logic [31:0] hs;
    logic [31:0] ps1;
    logic [31:0] exp_p;
    logic [31:0] exp_h;
    logic        ts;
    logic        ts_prev;
    logic        tov;
    logic        tpv;
    bit          chk_on;

    always #5 inclk = ~inclk;

    period_meter u_big (
        .inclk    (inclk),
        .reset    (reset),
        .sig_in   (sig_in),
        .period   (period_b),
        .high_time(high_b),
        .valid    (valid_b),
        .timeout  (timeout_b)
    );

    period_meter #(
        .CNT_W    (8),
        .MAX_COUNT(20)
    ) u_small (
        .inclk    (inclk),
        .reset    (reset),
        .sig_in   (sig_in),
        .period   (period_s),
        .high_time(high_s),
        .valid    (valid_s),
        .timeout  (timeout_s)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        @(posedge inclk);
        #1 sig_in = v;
        @(negedge inclk);
        ts_prev = ts;
        ts      = timeout_s;
        if (valid_b) begin
            nb++;
            pb = period_b;
            hb = high_b;
            if (chk_on) begin
                check("valid_period", period_b, exp_p);
                check("valid_high", high_b, exp_h);
            end
        end
        if (valid_s) begin
            if (ns == 0) begin
                ps1 = 32'(period_s);
                tov = timeout_s;
                tpv = ts_prev;
            end
            ns++;
            ps = 32'(period_s);
            hs = 32'(high_s);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic run(input int hi, input int lo, input int reps);
        repeat (reps) begin
            repeat (lo) step(1'b0);
            repeat (hi) step(1'b1);
        end
    endtask

    task automatic do_reset(input logic lvl);
        reset  = 1'b1;
        sig_in = lvl;
        repeat (3) @(posedge inclk);
        #1 reset = 1'b0;
        nb      = 0;
        ns      = 0;
        chk_on  = 1'b0;
        ts      = 1'b0;
        ts_prev = 1'b0;
        tov     = 1'b0;
        tpv     = 1'b0;
        ps1     = '0;
    endtask

    initial begin
        // reset state
        do_reset(1'b0);
        @(negedge inclk);
        check("rst_period", period_b, 32'd0);
        check("rst_high", high_b, 32'd0);
        check("rst_valid", 32'(valid_b), 32'd0);
        check("rst_timeout", 32'(timeout_b), 32'd0);
        check("rst_timeout_s", 32'(timeout_s), 32'd0);

        // symmetric 4/4 toggle: 6 rises give 5 results
        idle(5);
        exp_p  = 32'd8;
        exp_h  = 32'd4;
        chk_on = 1'b1;
        run(4, 4, 6);
        idle(4);
        check("sym_count", 32'(nb), 32'd5);
        check("sym_period", pb, 32'd8);
        check("sym_high", hb, 32'd4);

        // asymmetric high 3 / low 7
        do_reset(1'b0);
        idle(5);
        exp_p  = 32'd10;
        exp_h  = 32'd3;
        chk_on = 1'b1;
        run(3, 7, 5);
        idle(4);
        check("asym_count", 32'(nb), 32'd4);
        check("asym_period", pb, 32'd10);
        check("asym_high", hb, 32'd3);

        // input already high during reset must not give an edge
        do_reset(1'b1);
        repeat (5) step(1'b1);
        check("prime_no_valid", 32'(nb), 32'd0);
        exp_p  = 32'd10;
        exp_h  = 32'd5;
        chk_on = 1'b1;
        run(5, 5, 3);
        idle(4);
        check("prime_count", 32'(nb), 32'd2);
        check("prime_period", pb, 32'd10);

        // frozen input on the narrow instance: timeout 21 cycles after arming
        do_reset(1'b0);
        idle(5);
        step(1'b1);
        repeat (23) step(1'b1);
        check("to_before", 32'(ts), 32'd0);
        step(1'b1);
        check("to_set", 32'(ts), 32'd1);
        check("to_no_valid", 32'(ns), 32'd0);
        run(3, 3, 3);
        idle(4);
        check("to_restart_count", 32'(ns), 32'd2);
        check("to_restart_period", ps1, 32'd6);
        check("to_held_until_valid", 32'(tpv), 32'd1);
        check("to_clear_with_valid", 32'(tov), 32'd0);
        check("to_after", 32'(ts), 32'd0);

        // reset in the middle of a running measurement
        do_reset(1'b0);
        idle(5);
        run(4, 4, 3);
        idle(2);
        check("mid_pre_period", pb, 32'd8);
        reset = 1'b1;
        step(1'b0);
        check("mid_rst_period", period_b, 32'd0);
        check("mid_rst_high", high_b, 32'd0);
        check("mid_rst_valid", 32'(valid_b), 32'd0);
        check("mid_rst_timeout", 32'(timeout_b), 32'd0);
        reset  = 1'b0;
        nb     = 0;
        exp_p  = 32'd8;
        exp_h  = 32'd4;
        chk_on = 1'b1;
        idle(5);
        run(4, 4, 3);
        idle(4);
        check("mid_count", 32'(nb), 32'd2);
        check("mid_period", pb, 32'd8);

        // rise coincident with cnt==MAX_COUNT on the narrow instance
        do_reset(1'b0);
        idle(5);
        run(10, 11, 2);
        idle(4);
        check("max_count", 32'(ns), 32'd1);
        check("max_period", ps, 32'd21);
        check("max_high", hs, 32'd10);
        check("max_no_timeout", 32'(ts), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
